// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment driver: hex glyph table,
// dark-segment pattern and an anode-mask helper.
package seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // All-ones anode mask of the given width (up to 8 digits), i.e. every digit off
  function automatic logic [7:0] an_off(input int unsigned width);
    logic [8:0] ones;
    ones = (9'd1 << width) - 9'd1;
    return ones[7:0];
  endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low 7-segment glyph lookup.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] segs_c
);

  always_comb begin
    segs_c = HEX_SEG[value];
  end

endmodule

// File: rtl/seg_scan_n.sv
// Time-multiplexed N-digit common-anode 7-segment driver with frame snapshot,
// leading-zero suppression, blink and 8-level brightness.
module seg_scan_n
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_TICKS   = 100000,
  parameter int unsigned BLINK_FRAMES = 125
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*NUM_DIGITS-1:0]   digits,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     blank,
  input  logic [NUM_DIGITS-1:0]     blink,
  input  logic                      lz_en,
  input  logic [2:0]                bright,
  output logic [NUM_DIGITS-1:0]     an,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic                      frame_start
);

  localparam int unsigned TW      = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int unsigned IW      = $clog2(NUM_DIGITS);
  localparam int unsigned FW      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int unsigned SUB_LEN = SCAN_TICKS / 8;

  localparam logic [TW-1:0] TICK_LAST  = TW'(SCAN_TICKS - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  localparam logic [7:0]            AN_ALL  = an_off(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] AN_DARK = AN_ALL[NUM_DIGITS-1:0];

  logic [TW-1:0]           tick;
  logic [IW-1:0]           idx;
  logic [FW-1:0]           frame_cnt;
  logic                    blink_phase;
  logic                    load_pending;

  logic [4*NUM_DIGITS-1:0] snap_digits;
  logic [NUM_DIGITS-1:0]   snap_dp;
  logic [NUM_DIGITS-1:0]   snap_blank;
  logic [NUM_DIGITS-1:0]   snap_blink;
  logic                    snap_lz;
  logic [2:0]              snap_bright;

  logic                    frame_end_c;
  logic                    load_c;
  logic [2:0]              sub_c;
  logic [3:0]              digit_c;
  logic [6:0]              glyph_c;
  logic [NUM_DIGITS-1:0]   supp_c;
  logic                    lit_c;

  assign frame_end_c = (idx == IDX_LAST) && (tick == TICK_LAST);
  assign load_c      = load_pending | frame_end_c;
  assign sub_c       = 3'(32'(tick) / SUB_LEN);
  assign digit_c     = snap_digits[32'(idx)*4 +: 4];

  // The post-reset load cycle holds the counters so the first slot starts at tick 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick         <= '0;
      idx          <= '0;
      frame_cnt    <= '0;
      blink_phase  <= 1'b0;
      load_pending <= 1'b1;
    end else if (load_pending) begin
      load_pending <= 1'b0;
    end else begin
      if (tick == TICK_LAST) begin
        tick <= '0;
        idx  <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end else begin
        tick <= tick + TW'(1);
      end
      if (frame_end_c) begin
        if (frame_cnt == FRAME_LAST) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_digits <= '0;
      snap_dp     <= '0;
      snap_blank  <= '0;
      snap_blink  <= '0;
      snap_lz     <= 1'b0;
      snap_bright <= '0;
    end else if (load_c) begin
      snap_digits <= digits;
      snap_dp     <= dp_in;
      snap_blank  <= blank;
      snap_blink  <= blink;
      snap_lz     <= lz_en;
      snap_bright <= bright;
    end
  end

  // Suppression runs from the top digit down until a nonzero digit or a set dp
  always_comb begin
    logic active;
    supp_c = '0;
    active = snap_lz;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (active && (snap_digits[4*i +: 4] == 4'd0) && !snap_dp[i]) begin
        supp_c[i] = 1'b1;
      end else begin
        active = 1'b0;
      end
    end
  end

  assign lit_c = !load_pending && !snap_blank[idx] && !supp_c[idx] &&
                 !(snap_blink[idx] && blink_phase) && (sub_c <= snap_bright);

  seg_hex_decode u_dec (
    .value  (digit_c),
    .segs_c (glyph_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an          <= AN_DARK;
      seg         <= SEG_OFF;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      an          <= lit_c ? ~(NUM_DIGITS'(1) << idx) : AN_DARK;
      seg         <= lit_c ? glyph_c : SEG_OFF;
      dp          <= lit_c ? ~snap_dp[idx] : 1'b1;
      frame_start <= load_c;
    end
  end

endmodule

// File: tb/tb_seg_scan_n.sv
// Bench for seg_scan_n: directed and random scenarios checked every cycle
// against a frame-level model of the scan, snapshot, blink and suppression rules.
module tb_seg_scan_n;

  localparam int N  = 4;
  localparam int T  = 16;
  localparam int BF = 2;
  localparam int FRAME = N * T;

  logic           clk = 1'b0;
  logic           rst;
  logic [4*N-1:0] digits;
  logic [N-1:0]   dp_in, blank, blink;
  logic           lz_en;
  logic [2:0]     bright;
  logic [N-1:0]   an;
  logic [6:0]     seg;
  logic           dp;
  logic           frame_start;

  int checks = 0;
  int errors = 0;
  int n = 0;

  // Model snapshot, captured on the load edges
  logic [4*N-1:0] s_digits;
  logic [N-1:0]   s_dp, s_blank, s_blink;
  logic           s_lz;
  logic [2:0]     s_bright;

  seg_scan_n #(.NUM_DIGITS(N), .SCAN_TICKS(T), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .digits(digits), .dp_in(dp_in), .blank(blank),
    .blink(blink), .lz_en(lz_en), .bright(bright), .an(an), .seg(seg),
    .dp(dp), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000; 4'h1: return 7'b1111001;
      4'h2: return 7'b0100100; 4'h3: return 7'b0110000;
      4'h4: return 7'b0011001; 4'h5: return 7'b0010010;
      4'h6: return 7'b0000010; 4'h7: return 7'b1111000;
      4'h8: return 7'b0000000; 4'h9: return 7'b0010000;
      4'hA: return 7'b0001000; 4'hB: return 7'b0000011;
      4'hC: return 7'b1000110; 4'hD: return 7'b0100001;
      4'hE: return 7'b0000110; default: return 7'b0001110;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (edge %0d)", tag, obs, exp, n);
    end
  endtask

  // One clock: predict outputs from the global step count, update model snapshot, compare
  task automatic step();
    logic [N-1:0] e_an;
    logic [6:0]   e_seg;
    logic         e_dp, e_fs, lit;
    int k, f, r, d, tk, sub, h;
    @(posedge clk);
    n++;
    e_an = '1; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0;
    if (n == 1) begin
      e_fs = 1'b1;
    end else begin
      k   = n - 2;
      f   = k / FRAME;
      r   = k % FRAME;
      d   = r / T;
      tk  = r % T;
      sub = tk / (T / 8);
      e_fs = (r == FRAME - 1);
      h = 0;
      for (int i = N - 1; i >= 0; i--)
        if (h == 0 && (s_digits[4*i +: 4] != 4'd0 || s_dp[i])) h = i;
      lit = !s_blank[d] && !(s_lz && d > h) &&
            !(s_blink[d] && ((f / BF) % 2 == 1)) && (sub <= int'(s_bright));
      if (lit) begin
        e_an     = '1;
        e_an[d]  = 1'b0;
        e_seg    = glyph(s_digits[4*d +: 4]);
        e_dp     = ~s_dp[d];
      end
    end
    if (n == 1 || (n - 1) % FRAME == 0) begin
      s_digits = digits; s_dp = dp_in; s_blank = blank; s_blink = blink;
      s_lz = lz_en; s_bright = bright;
    end
    #1;
    check("an", 32'(an), 32'(e_an));
    check("seg", 32'(seg), 32'(e_seg));
    check("dp", 32'(dp), 32'(e_dp));
    check("frame_start", 32'(frame_start), 32'(e_fs));
  endtask

  task automatic run(input int cycles);
    for (int c = 0; c < cycles; c++) step();
  endtask

  task automatic set_in(input logic [15:0] d, input logic [3:0] p, input logic [3:0] bl,
                        input logic [3:0] bk, input logic lz, input logic [2:0] br);
    digits = d; dp_in = p; blank = bl; blink = bk; lz_en = lz; bright = br;
  endtask

  initial begin
    rst = 1'b1;
    set_in(16'h1234, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'd7);
    #7;
    check("reset_an", 32'(an), 32'hF);
    check("reset_seg", 32'(seg), 32'h7F);
    check("reset_dp", 32'(dp), 32'h1);
    check("reset_fs", 32'(frame_start), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; n = 0;

    run(2 * FRAME);
    // Mid-frame input change only shows after the next load
    set_in(16'h0040, 4'b0000, 4'b0000, 4'b0000, 1'b1, 3'd7);
    run(FRAME + 20);
    set_in(16'h0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 3'd7);
    run(2 * FRAME);
    set_in(16'h0005, 4'b0100, 4'b0000, 4'b0000, 1'b1, 3'd7);
    run(2 * FRAME);
    set_in(16'hABCD, 4'b1010, 4'b0000, 4'b0000, 1'b0, 3'd1);
    run(2 * FRAME);
    set_in(16'h8E0F, 4'b0001, 4'b0010, 4'b0000, 1'b0, 3'd0);
    run(2 * FRAME);
    set_in(16'h9876, 4'b0000, 4'b0000, 4'b0001, 1'b0, 3'd7);
    run(5 * FRAME);

    for (int j = 0; j < 24; j++) begin
      set_in(16'($urandom), 4'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0),
             4'($urandom), 1'($urandom), 3'($urandom));
      if ($urandom_range(0, 1) == 1) digits[15:8] = 8'h00;
      run(int'($urandom_range(10, 90)));
    end

    // Asynchronous reset mid-slot must blank the anodes within the cycle
    set_in(16'h1234, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3'd7);
    run(FRAME + 5);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_an", 32'(an), 32'hF);
    check("midrst_seg", 32'(seg), 32'h7F);
    check("midrst_dp", 32'(dp), 32'h1);
    @(posedge clk); #1;
    rst = 1'b0; n = 0;
    run(FRAME + 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_n.md
# seg_scan_n

Parametrised, time-multiplexed 7-segment display driver for N common-anode digits on the 100 MHz board clock. Accepts a packed hex digit bus plus per-digit decimal-point, blank and blink masks. Adds leading-zero suppression, 8-level brightness and a frame-synchronous input snapshot that prevents tearing. Sits between the clock/counter datapath and the board `an`/`seg`/`dp` pins.

## Interface
- `NUM_DIGITS`, default 4: digit count, legal range 2..8.
- `SCAN_TICKS`, default 100000: clock cycles per digit slot (1 ms at 100 MHz); multiple of 8, ≥ 8.
- `BLINK_FRAMES`, default 125: full scan frames per blink half-period (0.5 s with the defaults).
- `clk`  in  1: board clock. One clock domain.
- `rst`  in  1: reset, asynchronous and active-high.
- `digits`  in  4*NUM_DIGITS: hex values; digit i is `digits[4i+3:4i]`; digit 0 is the rightmost.
- `dp_in`  in  NUM_DIGITS: decimal point request per digit.
- `blank`  in  NUM_DIGITS: force digit fully dark.
- `blink`  in  NUM_DIGITS: digit follows the blink phase.
- `lz_en`  in  1: enable leading-zero suppression.
- `bright`  in  3: duty level, on-time = (bright+1)/8 of each slot.
- `an`  out  NUM_DIGITS: active-low anode enables.
- `seg`  out  7: active-low cathodes, bit order {g,f,e,d,c,b,a}.
- `dp`  out  1: active-low decimal point.
- `frame_start`  out  1: one-cycle pulse when the snapshot loads.

## Operation
- `tick` counts 0..SCAN_TICKS-1 and wraps. At wrap, `idx` advances 0→1→…→NUM_DIGITS-1→0.
- `sub` = tick / (SCAN_TICKS/8), range 0..7. The selected digit is lit only while `sub` ≤ `bright`. `bright`=7 gives full on-time.
- Snapshot registers hold `digits`, `dp_in`, `blank`, `blink`, `lz_en` and `bright`. They load when idx=NUM_DIGITS-1 and tick=SCAN_TICKS-1, and once on the first cycle after reset release. `frame_start` pulses on every load. Input changes between loads are invisible on the outputs.
- Frame counter: 0..BLINK_FRAMES-1, advances on each load. `blink_phase` toggles when it wraps.
- Leading-zero suppression (snapshot `lz_en`=1):
  - Scan from digit NUM_DIGITS-1 downward.
  - A digit is suppressed while it and every higher digit equal 0 and have dp clear.
  - The first nonzero digit, or the first digit with dp set, ends suppression.
  - Digit 0 is never suppressed.
- Digit i is dark when any of these holds: blank[i]; suppressed; blink[i] with blink_phase=1; outside its duty window. Dark means `an` all 1, `seg`=7'h7F, `dp`=1.
- Otherwise: `an` has only bit idx low, `seg` = hex decode of the digit, `dp` = ~dp_in[idx].
- Decode is full hex 0–F, active low. Examples: 0=7'b1000000, 1=7'b1111001, 8=7'b0000000, A=7'b0001000, F=7'b0001110.

## Timing
- `an`, `seg`, `dp` and `frame_start` are registered and lag the `idx`/`tick`/`sub` state by exactly 1 cycle.
- Reset values:
  - Outputs: `an`=all 1, `seg`=7'h7F, `dp`=1, `frame_start`=0.
  - Internal state: tick=0, idx=0, frame counter=0, blink_phase=0, snapshot=0, first-load flag pending.
- Reset asserted mid-frame blanks all outputs immediately. After release, scanning restarts at idx 0, tick 0.
- Slot boundary: at most one anode is low in any cycle. The changeover from one anode to the next happens in a single cycle.
- The snapshot load and a blink_phase toggle in the same cycle both take effect on the next slot, digit 0.

## Structure
- Package `seg_pkg`:
  - Hex-to-segment constant table (16 × 7 bits).
  - `SEG_OFF`=7'h7F.
  - `AN_OFF` function of width.
- Sub-module `seg_hex_decode`: combinational 4-bit to 7-bit lookup, instantiated once on the muxed digit.
- Counter widths: tick uses $clog2(SCAN_TICKS), idx uses $clog2(NUM_DIGITS), frame counter uses $clog2(BLINK_FRAMES).

## Test plan
All scenarios use NUM_DIGITS=4, SCAN_TICKS=16, BLINK_FRAMES=2.
- Reset then release, digits=16'h1234, bright=7. Expected `an` sequence: 1110 (seg 0011001), 1101, 1011, 0111, 16 cycles each; `frame_start` once per 64 cycles.
- lz_en=1, digits=16'h0040, dp_in=0. Digits 3 and 2 stay dark; digit 1 shows 4; digit 0 shows 0. With digits=16'h0000, only digit 0 is lit.
- lz_en=1, digits=16'h0005, dp_in=4'b0100. Digit 2 shows 0 with dp=0; digit 3 is dark.
- bright=1: each anode is low for exactly 4 of its 16 cycles (sub 0–1). bright=0: each anode is low for 2 cycles.
- blink=4'b0001: digit 0 is lit in frames 0–1, dark in frames 2–3, and repeats.
- Change `digits` mid-frame: outputs change only after the next `frame_start`. Assert `rst` mid-slot: `an`=1111 in the same cycle.
